gsu_mem_responder: RTL and testbench
====================================

// Module: gsu_mem_responder
// PURPOSE
//  Memory-side responder for the GSU cartridge mapper. It services the mapper's
//  ROM reads and BSRAM reads/writes from a single 16-bit SDRAM-style memory port.
//  Results are held on ROM_Q/BSRAM_Q until the next fetch. Sits between the mapper
//  and the top-level SDRAM arbiter; the mapper issues no wait states.
// PARAMETERS
//  MEM_AW    25         memory port address width (byte address)
//  ROM_BASE  25'h0      byte offset of ROM image in memory
//  RAM_BASE  25'h600000 byte offset of BSRAM image in memory
// PORTS
//  MCLK        in   1   master clock; all logic on rising edge
//  RST         in   1   reset, synchronous, active-high
//  ROM_ADDR    in   23  mapper ROM byte address (already masked)
//  ROM_OE_N    in   1   ROM read strobe, active low
//  ROM_Q       out  16  ROM word holding the addressed byte
//  BSRAM_ADDR  in   20  mapper BSRAM byte address
//  BSRAM_D     in   8   BSRAM write data
//  BSRAM_CE_N  in   1   BSRAM select, active low
//  BSRAM_OE_N  in   1   BSRAM read strobe, active low
//  BSRAM_WE_N  in   1   BSRAM write strobe, active low
//  BSRAM_Q     out  8   BSRAM read byte
//  MEM_REQ     out  1   request valid; held until MEM_READY
//  MEM_READY   in   1   arbiter accepts the request this cycle
//  MEM_WE      out  1   1 = write, 0 = read
//  MEM_ADDR    out  MEM_AW  byte address; bit0 selects the byte lane for writes
//  MEM_WDATA   out  16  {BSRAM_D, BSRAM_D}
//  MEM_BE      out  2   byte enables: 2'b01 even byte, 2'b10 odd byte, 2'b11 read
//  MEM_RVALID  in   1   read data valid, one cycle, in request order
//  MEM_RDATA   in   16  read data
//  BUSY        out  1   request outstanding or pending (debug/perf only)
// BEHAVIOUR
//  Reset values: ROM_Q=0, BSRAM_Q=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_BE=0,
//   BUSY=0. All caches and pending flags are cleared.
//  Request detection (registered inputs, one-cycle sample delay):
//   - ROM rd: ROM_OE_N=0 and (ROM word tag invalid or ROM_ADDR[22:1] != tag).
//   - RAM wr: falling edge of (BSRAM_CE_N|BSRAM_WE_N). Addr/data are latched at
//     the edge. Exactly one write per edge. A write to the cached RAM address
//     updates BSRAM_Q directly.
//   - RAM rd: BSRAM_CE_N=0, BSRAM_OE_N=0, WE_N=1, and (RAM tag invalid or
//     BSRAM_ADDR != tag).
//   - Each class owns a one-deep pending slot. A newer detection of the same
//     class overwrites the slot; the latest address wins.
//  Arbitration on issue: RAM wr > RAM rd > ROM rd. Fixed priority, evaluated only
//   in IDLE.
//  FSM states: IDLE, ISSUE, WAIT.
//   - IDLE -> ISSUE when any slot is pending. Selects the slot, drives MEM_*, and
//     sets MEM_REQ=1.
//   - ISSUE: MEM_REQ is held with stable MEM_* until MEM_READY=1.
//     Write -> IDLE. Read -> WAIT.
//   - WAIT: on MEM_RVALID. ROM: ROM_Q<=MEM_RDATA, tag<=addr[22:1], valid<=1.
//     RAM: BSRAM_Q<=addr[0] ? RDATA[15:8] : RDATA[7:0], tag<=addr, valid<=1.
//     Then -> IDLE.
//  Addressing:
//   - ROM: MEM_ADDR = ROM_BASE + {ROM_ADDR[22:1],1'b0}.
//   - RAM: MEM_ADDR = RAM_BASE + BSRAM_ADDR. Zero-extend to MEM_AW; wrap modulo
//     2^MEM_AW.
//  Latency: ROM_OE_N low to ISSUE = 2 cycles when IDLE. ROM_Q updates the cycle
//   after MEM_RVALID. A cache hit causes no memory traffic and leaves ROM_Q
//   unchanged.
//  Boundary cases:
//   - Detection coinciding with slot consumption: the new request stays pending.
//   - MEM_RVALID outside WAIT is ignored. This covers responses to requests
//     abandoned by RST.
//   - RST mid-ISSUE/WAIT: MEM_REQ drops next cycle and the transaction is
//     abandoned.
//   - A RAM write to the same word as the ROM tag does not invalidate it
//     (separate images).
//  BUSY = (state!=IDLE) | any pending slot.
// STRUCTURE
//  Shared package gsu_mem_pkg: state enum (IDLE/ISSUE/WAIT), request-class codes,
//   BE constants.
//  One sub-module: gsu_req_slot (edge/tag-miss detect plus one-deep pending
//   latch), instantiated three times. FSM and data capture stay in this module.
// TESTING
//  1 ROM_OE_N=0, ROM_ADDR=23'h000101, READY=1; RVALID returns 16'hBEEF 3 cycles
//    later -> one read to addr 25'h100, BE=2'b11; ROM_Q=16'hBEEF.
//  2 Then ROM_ADDR=23'h000100 (same word) -> no MEM_REQ; ROM_Q stays 16'hBEEF.
//  3 BSRAM write of 8'h5A at 20'h00003 with CE low, WE held low 10 cycles -> exactly
//    one write: MEM_ADDR=RAM_BASE+3, BE=2'b10, WDATA=16'h5A5A.
//  4 Same cycle: ROM miss and RAM write pending -> write issues first, then ROM
//    read; both complete.
//  5 READY held low 5 cycles -> MEM_REQ and MEM_* stable throughout; BUSY=1.
//  6 RST asserted in WAIT, RVALID arrives after reset -> ROM_Q stays 0 and state
//    returns to IDLE.

Source files
------------

// File: rtl/gsu_mem_pkg.sv
// Shared types and constants for the GSU memory responder: FSM states,
// request classes and byte-enable codes.
package gsu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_RAM_WR,
        CLS_RAM_RD,
        CLS_ROM_RD
    } req_cls_t;

    localparam logic [1:0] BE_EVEN = 2'b01;
    localparam logic [1:0] BE_ODD  = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic [1:0] write_be(input logic lane);
        return lane ? BE_ODD : BE_EVEN;
    endfunction

endpackage

// File: rtl/gsu_req_slot.sv
// Request detector plus one-deep pending slot. The newest detection overwrites
// the slot, and a detection in the same cycle as consumption keeps it pending.
module gsu_req_slot
    import gsu_mem_pkg::*;
#(
    parameter int AW   = 22,
    parameter bit EDGE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          strobe,
    input  logic [AW-1:0] addr,
    input  logic          tag_valid,
    input  logic [AW-1:0] tag,
    input  logic          flight_valid,
    input  logic [AW-1:0] flight_addr,
    input  logic          consume,
    output logic          pending,
    output logic [AW-1:0] pend_addr
);

    logic strobe_q;
    logic qual;
    logic hit;
    logic dup;
    logic fire;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) strobe_q <= 1'b0;
        else     strobe_q <= strobe;
    end

    // Level reads must not re-arm for an address already queued or in flight.
    assign qual = EDGE ? (strobe && !strobe_q) : strobe;
    assign hit  = tag_valid && (addr == tag);
    assign dup  = !EDGE && ((pending && (addr == pend_addr)) ||
                            (flight_valid && (addr == flight_addr)));
    assign fire = qual && !hit && !dup;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pend_addr <= '0;
        end else if (fire) begin
            pending   <= 1'b1;
            pend_addr <= addr;
        end else if (consume) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: rtl/gsu_mem_responder.sv
// Memory-side responder for the GSU mapper: serves ROM word reads and BSRAM
// byte reads/writes over one 16-bit request/response memory port.
module gsu_mem_responder
    import gsu_mem_pkg::*;
#(
    parameter int                MEM_AW   = 25,
    parameter logic [MEM_AW-1:0] ROM_BASE = 25'h0,
    parameter logic [MEM_AW-1:0] RAM_BASE = 25'h600000
) (
    input  logic              MCLK,
    input  logic              RST,
    input  logic [22:0]       ROM_ADDR,
    input  logic              ROM_OE_N,
    output logic [15:0]       ROM_Q,
    input  logic [19:0]       BSRAM_ADDR,
    input  logic [7:0]        BSRAM_D,
    input  logic              BSRAM_CE_N,
    input  logic              BSRAM_OE_N,
    input  logic              BSRAM_WE_N,
    output logic [7:0]        BSRAM_Q,
    output logic              MEM_REQ,
    input  logic              MEM_READY,
    output logic              MEM_WE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic [1:0]        MEM_BE,
    input  logic              MEM_RVALID,
    input  logic [15:0]       MEM_RDATA,
    output logic              BUSY
);

    state_t      state, state_next;
    req_cls_t    sel, cur_cls;
    logic [21:0] cur_addr;

    logic [21:0] rom_word_r;
    logic        rom_rd_r;
    logic [19:0] ram_addr_r;
    logic [7:0]  ram_d_r;
    logic        ram_rd_r;
    logic        ram_wr_r;

    logic [21:0] rom_tag;
    logic        rom_tag_valid;
    logic [19:0] ram_tag;
    logic        ram_tag_valid;

    logic        wr_pending, ram_rd_pending, rom_rd_pending;
    logic [27:0] wr_payload;
    logic [19:0] ram_rd_addr;
    logic [21:0] rom_rd_word;
    logic        wr_consume, ram_rd_consume, rom_rd_consume;

    always_ff @(posedge MCLK) begin
        if (RST) begin
            rom_word_r <= '0;
            rom_rd_r   <= 1'b0;
            ram_addr_r <= '0;
            ram_d_r    <= '0;
            ram_rd_r   <= 1'b0;
            ram_wr_r   <= 1'b0;
        end else begin
            rom_word_r <= ROM_ADDR[22:1];
            rom_rd_r   <= !ROM_OE_N;
            ram_addr_r <= BSRAM_ADDR;
            ram_d_r    <= BSRAM_D;
            ram_rd_r   <= !BSRAM_CE_N && !BSRAM_OE_N && BSRAM_WE_N;
            ram_wr_r   <= !(BSRAM_CE_N || BSRAM_WE_N);
        end
    end

    // Write payload carries {data, address}; each strobe edge is one write.
    gsu_req_slot #(.AW(28), .EDGE(1'b1)) u_ram_wr (
        .clk(MCLK), .rst(RST), .strobe(ram_wr_r), .addr({ram_d_r, ram_addr_r}),
        .tag_valid(1'b0), .tag('0), .flight_valid(1'b0), .flight_addr('0),
        .consume(wr_consume), .pending(wr_pending), .pend_addr(wr_payload)
    );

    gsu_req_slot #(.AW(20), .EDGE(1'b0)) u_ram_rd (
        .clk(MCLK), .rst(RST), .strobe(ram_rd_r), .addr(ram_addr_r),
        .tag_valid(ram_tag_valid), .tag(ram_tag),
        .flight_valid((state != ST_IDLE) && (cur_cls == CLS_RAM_RD)),
        .flight_addr(cur_addr[19:0]),
        .consume(ram_rd_consume), .pending(ram_rd_pending), .pend_addr(ram_rd_addr)
    );

    gsu_req_slot #(.AW(22), .EDGE(1'b0)) u_rom_rd (
        .clk(MCLK), .rst(RST), .strobe(rom_rd_r), .addr(rom_word_r),
        .tag_valid(rom_tag_valid), .tag(rom_tag),
        .flight_valid((state != ST_IDLE) && (cur_cls == CLS_ROM_RD)),
        .flight_addr(cur_addr),
        .consume(rom_rd_consume), .pending(rom_rd_pending), .pend_addr(rom_rd_word)
    );

    assign sel = wr_pending     ? CLS_RAM_WR :
                 ram_rd_pending ? CLS_RAM_RD :
                 rom_rd_pending ? CLS_ROM_RD : CLS_NONE;

    always_ff @(posedge MCLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (sel != CLS_NONE) state_next = ST_ISSUE;
            ST_ISSUE: if (MEM_READY) state_next = (cur_cls == CLS_RAM_WR) ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (MEM_RVALID) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_consume     = (state == ST_IDLE) && (sel == CLS_RAM_WR);
        ram_rd_consume = (state == ST_IDLE) && (sel == CLS_RAM_RD);
        rom_rd_consume = (state == ST_IDLE) && (sel == CLS_ROM_RD);
        MEM_REQ        = (state == ST_ISSUE);
        BUSY           = (state != ST_IDLE) || wr_pending || ram_rd_pending || rom_rd_pending;
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            cur_cls       <= CLS_NONE;
            cur_addr      <= '0;
            MEM_WE        <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_BE        <= '0;
            MEM_WDATA     <= '0;
            ROM_Q         <= '0;
            BSRAM_Q       <= '0;
            rom_tag       <= '0;
            rom_tag_valid <= 1'b0;
            ram_tag       <= '0;
            ram_tag_valid <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                unique case (sel)
                    CLS_RAM_WR: begin
                        cur_cls   <= CLS_RAM_WR;
                        cur_addr  <= 22'(wr_payload[19:0]);
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= RAM_BASE + MEM_AW'(wr_payload[19:0]);
                        MEM_BE    <= write_be(wr_payload[0]);
                        MEM_WDATA <= {wr_payload[27:20], wr_payload[27:20]};
                        // Keep the cached BSRAM byte coherent with our own writes.
                        if (ram_tag_valid && (ram_tag == wr_payload[19:0]))
                            BSRAM_Q <= wr_payload[27:20];
                    end
                    CLS_RAM_RD: begin
                        cur_cls  <= CLS_RAM_RD;
                        cur_addr <= 22'(ram_rd_addr);
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= RAM_BASE + MEM_AW'(ram_rd_addr);
                        MEM_BE   <= BE_WORD;
                    end
                    CLS_ROM_RD: begin
                        cur_cls  <= CLS_ROM_RD;
                        cur_addr <= rom_rd_word;
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= ROM_BASE + MEM_AW'({rom_rd_word, 1'b0});
                        MEM_BE   <= BE_WORD;
                    end
                    default: ;
                endcase
            end
            if ((state == ST_WAIT) && MEM_RVALID) begin
                if (cur_cls == CLS_ROM_RD) begin
                    ROM_Q         <= MEM_RDATA;
                    rom_tag       <= cur_addr;
                    rom_tag_valid <= 1'b1;
                end else begin
                    BSRAM_Q       <= cur_addr[0] ? MEM_RDATA[15:8] : MEM_RDATA[7:0];
                    ram_tag       <= cur_addr[19:0];
                    ram_tag_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsu_mem_responder.sv
// Directed bench: stimulus queues expected memory requests, a memory-side
// monitor pops and compares each accepted request and returns read data.
module tb_gsu_mem_responder;

    logic        MCLK = 1'b0;
    logic        RST;
    logic [22:0] ROM_ADDR;
    logic        ROM_OE_N;
    logic [15:0] ROM_Q;
    logic [19:0] BSRAM_ADDR;
    logic [7:0]  BSRAM_D;
    logic        BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N;
    logic [7:0]  BSRAM_Q;
    logic        MEM_REQ, MEM_READY, MEM_WE;
    logic [24:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [1:0]  MEM_BE;
    logic        MEM_RVALID;
    logic [15:0] MEM_RDATA;
    logic        BUSY;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } req_t;

    req_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          rvalid_delay = 3;
    int          wr_count = 0;
    logic [15:0] rd_data;

    gsu_mem_responder dut (
        .MCLK(MCLK), .RST(RST),
        .ROM_ADDR(ROM_ADDR), .ROM_OE_N(ROM_OE_N), .ROM_Q(ROM_Q),
        .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D), .BSRAM_CE_N(BSRAM_CE_N),
        .BSRAM_OE_N(BSRAM_OE_N), .BSRAM_WE_N(BSRAM_WE_N), .BSRAM_Q(BSRAM_Q),
        .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic expect_req(input logic we, input logic [24:0] addr, input logic [1:0] be,
                              input logic [15:0] wdata, input logic [15:0] rdata);
        req_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata; r.rdata = rdata;
        sb.push_back(r);
    endtask

    task automatic wait_rom(input logic [15:0] exp, input int limit);
        for (int i = 0; i < limit && ROM_Q !== exp; i++) cyc(1);
    endtask

    task automatic wait_bsram(input logic [7:0] exp, input int limit);
        for (int i = 0; i < limit && BSRAM_Q !== exp; i++) cyc(1);
    endtask

    // Memory side: returns read data after rvalid_delay cycles, checks requests.
    initial begin
        logic        held;
        logic [43:0] snap;
        req_t        e;
        held = 1'b0;
        snap = '0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        forever begin
            @(negedge MCLK);
            #1;
            MEM_RVALID = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    MEM_RVALID = 1'b1;
                    MEM_RDATA  = rd_data;
                end
            end
            if (held) begin
                check("req_held", 64'(MEM_REQ), 64'd1);
                check("req_stable", 64'({MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}), 64'(snap));
            end
            if (MEM_REQ && MEM_READY) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got we=%0b addr=%0h with no request expected",
                             MEM_WE, MEM_ADDR);
                end else begin
                    e = sb.pop_front();
                    check("req_we", 64'(MEM_WE), 64'(e.we));
                    check("req_addr", 64'(MEM_ADDR), 64'(e.addr));
                    check("req_be", 64'(MEM_BE), 64'(e.be));
                    if (e.we) begin
                        check("req_wdata", 64'(MEM_WDATA), 64'(e.wdata));
                        wr_count++;
                    end else begin
                        rd_cnt  = rvalid_delay;
                        rd_data = e.rdata;
                    end
                end
            end else if (MEM_REQ) begin
                held = 1'b1;
                snap = {MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        RST = 1'b1; ROM_ADDR = '0; ROM_OE_N = 1'b1;
        BSRAM_ADDR = '0; BSRAM_D = '0; BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1; BSRAM_WE_N = 1'b1;
        MEM_READY = 1'b1;
        cyc(3);
        check("rst_rom_q", 64'(ROM_Q), 64'h0);
        check("rst_bsram_q", 64'(BSRAM_Q), 64'h0);
        check("rst_req", 64'(MEM_REQ), 64'h0);
        check("rst_we", 64'(MEM_WE), 64'h0);
        check("rst_addr", 64'(MEM_ADDR), 64'h0);
        check("rst_be", 64'(MEM_BE), 64'h0);
        check("rst_busy", 64'(BUSY), 64'h0);
        RST = 1'b0;
        cyc(2);

        // 1: ROM miss, word address 0x100, two-cycle issue latency
        expect_req(1'b0, 25'h100, 2'b11, 16'h0, 16'hBEEF);
        ROM_ADDR = 23'h000101; ROM_OE_N = 1'b0;
        cyc(2);
        check("t1_no_req_yet", 64'(MEM_REQ), 64'h0);
        cyc(1);
        check("t1_req_issue", 64'(MEM_REQ), 64'h1);
        wait_rom(16'hBEEF, 20);
        check("t1_rom_q", 64'(ROM_Q), 64'hBEEF);
        cyc(3);
        check("t1_idle", 64'(BUSY), 64'h0);

        // 2: same word, other byte: cache hit, no traffic
        ROM_ADDR = 23'h000100;
        cyc(6);
        check("t2_rom_q", 64'(ROM_Q), 64'hBEEF);
        check("t2_busy", 64'(BUSY), 64'h0);
        ROM_OE_N = 1'b1;
        cyc(2);

        // 3: long write strobe gives exactly one odd-lane write
        wr_before = wr_count;
        expect_req(1'b1, 25'h600003, 2'b10, 16'h5A5A, 16'h0);
        BSRAM_ADDR = 20'h00003; BSRAM_D = 8'h5A; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
        cyc(10);
        BSRAM_WE_N = 1'b1; BSRAM_CE_N = 1'b1;
        cyc(4);
        check("t3_one_write", 64'(wr_count - wr_before), 64'd1);
        check("t3_drained", 64'(sb.size()), 64'd0);

        // RAM read at odd address picks the high byte
        expect_req(1'b0, 25'h600003, 2'b11, 16'h0, 16'h7E21);
        BSRAM_CE_N = 1'b0; BSRAM_OE_N = 1'b0;
        wait_bsram(8'h7E, 20);
        check("ram_rd_odd", 64'(BSRAM_Q), 64'h7E);
        BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1;
        cyc(2);

        // Write to the cached RAM address updates BSRAM_Q without a read
        expect_req(1'b1, 25'h600003, 2'b10, 16'h9999, 16'h0);
        BSRAM_D = 8'h99; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
        cyc(3);
        BSRAM_CE_N = 1'b1; BSRAM_WE_N = 1'b1;
        cyc(6);
        check("ram_wr_hit", 64'(BSRAM_Q), 64'h99);

        // RAM read at even address picks the low byte
        expect_req(1'b0, 25'h600010, 2'b11, 16'h0, 16'hABCD);
        BSRAM_ADDR = 20'h00010; BSRAM_CE_N = 1'b0; BSRAM_OE_N = 1'b0;
        wait_bsram(8'hCD, 20);
        check("ram_rd_even", 64'(BSRAM_Q), 64'hCD);
        BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1;
        cyc(2);

        // 4: ROM miss and RAM write together: write first, then ROM
        expect_req(1'b1, 25'h600020, 2'b01, 16'h3C3C, 16'h0);
        expect_req(1'b0, 25'h001234, 2'b11, 16'h0, 16'h1357);
        ROM_ADDR = 23'h001234; ROM_OE_N = 1'b0;
        BSRAM_ADDR = 20'h00020; BSRAM_D = 8'h3C; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
        wait_rom(16'h1357, 30);
        check("t4_rom_q", 64'(ROM_Q), 64'h1357);
        check("t4_bsram_q", 64'(BSRAM_Q), 64'hCD);
        check("t4_drained", 64'(sb.size()), 64'd0);
        ROM_OE_N = 1'b1; BSRAM_CE_N = 1'b1; BSRAM_WE_N = 1'b1;
        cyc(3);

        // 5: arbiter stalls five cycles
        MEM_READY = 1'b0;
        expect_req(1'b0, 25'h000400, 2'b11, 16'h0, 16'h2468);
        ROM_ADDR = 23'h000400; ROM_OE_N = 1'b0;
        for (int i = 0; i < 10 && !MEM_REQ; i++) cyc(1);
        check("t5_req", 64'(MEM_REQ), 64'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t5_req_hold", 64'(MEM_REQ), 64'h1);
            check("t5_busy", 64'(BUSY), 64'h1);
            check("t5_addr", 64'(MEM_ADDR), 64'h400);
        end
        MEM_READY = 1'b1;
        wait_rom(16'h2468, 20);
        check("t5_rom_q", 64'(ROM_Q), 64'h2468);
        ROM_OE_N = 1'b1;
        cyc(3);

        // 6: reset while waiting for data; late RVALID is ignored
        rvalid_delay = 8;
        expect_req(1'b0, 25'h000800, 2'b11, 16'h0, 16'hDEAD);
        ROM_ADDR = 23'h000800; ROM_OE_N = 1'b0;
        for (int i = 0; i < 10 && rd_cnt == 0; i++) cyc(1);
        cyc(1);
        RST = 1'b1; ROM_OE_N = 1'b1;
        cyc(1);
        check("t6_req_drop", 64'(MEM_REQ), 64'h0);
        check("t6_rom_q_rst", 64'(ROM_Q), 64'h0);
        cyc(1);
        RST = 1'b0;
        cyc(12);
        check("t6_rom_q", 64'(ROM_Q), 64'h0);
        check("t6_busy", 64'(BUSY), 64'h0);
        check("t6_req", 64'(MEM_REQ), 64'h0);
        check("t6_addr", 64'(MEM_ADDR), 64'h0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
